// File: rtl/uart_alu_sequencer.sv
// Frame sequencer between a byte UART and a combinational ALU: collects operand1, operand2 and
// opcode, captures the result, and sends it back high byte first. Define SEQ_TIMEOUT_EN to abandon
// partial frames after TIMEOUT_CYCLES idle clocks.
module uart_alu_sequencer #(
    parameter int unsigned NB_DATA        = 8,
    parameter int unsigned NB_OP          = 6,
    parameter int unsigned NB_OUT         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NB_DATA-1:0]       i_rx_data,
    input  logic                     i_rx_done,
    input  logic                     i_tx_busy,
    input  logic signed [NB_OUT-1:0] i_alu_result,
    output logic [NB_DATA-1:0]       o_operand1,
    output logic [NB_DATA-1:0]       o_operand2,
    output logic [NB_OP-1:0]         o_opcode,
    output logic                     o_tx_start,
    output logic [NB_DATA-1:0]       o_tx_data,
    output logic                     o_busy,
    output logic                     o_rx_drop,
    output logic                     o_frame_err
);

    if (NB_OUT != 2 * NB_DATA || NB_OP > NB_DATA || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("uart_alu_sequencer: inconsistent parameters");
    end

    typedef enum logic [2:0] {
        StIdle, StWaitB, StWaitOp, StExec, StTxHi, StWaitHi, StTxLo, StWaitLo
    } state_e;

    state_e              state_q, state_d;
    logic [NB_DATA-1:0]  op1_q, op1_d, op2_q, op2_d;
    logic [NB_OP-1:0]    opcode_q, opcode_d;
    logic [NB_OUT-1:0]   result_q, result_d;
    logic                seen_busy_q, seen_busy_d;
    logic                tx_start, rx_drop;

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            frame_err_q, frame_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        opcode_d    = opcode_q;
        result_d    = result_q;
        seen_busy_d = seen_busy_q;
        tx_start    = 1'b0;
        rx_drop     = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        cnt_d       = '0;
        frame_err_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: if (i_rx_done) begin
                op1_d   = i_rx_data;
                state_d = StWaitB;
            end
            StWaitB: if (i_rx_done) begin
                op2_d   = i_rx_data;
                state_d = StWaitOp;
            end
            StWaitOp: if (i_rx_done) begin
                opcode_d = i_rx_data[NB_OP-1:0];
                state_d  = StExec;
            end
            StExec: begin
                rx_drop  = i_rx_done;
                result_d = i_alu_result;
                state_d  = StTxHi;
            end
            StTxHi, StTxLo: begin
                rx_drop = i_rx_done;
                if (!i_tx_busy) begin
                    tx_start    = 1'b1;
                    seen_busy_d = 1'b0;
                    state_d     = (state_q == StTxHi) ? StWaitHi : StWaitLo;
                end
            end
            StWaitHi, StWaitLo: begin
                rx_drop = i_rx_done;
                // Completion is a busy high-then-low sequence, not merely busy being low.
                if (i_tx_busy) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    seen_busy_d = 1'b0;
                    state_d     = (state_q == StWaitHi) ? StTxLo : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef SEQ_TIMEOUT_EN
        // An arriving byte beats expiry in the same cycle.
        if ((state_q == StWaitB || state_q == StWaitOp) && !i_rx_done) begin
            if (cnt_q == TimeoutLast) begin
                state_d     = StIdle;
                op1_d       = '0;
                op2_d       = '0;
                opcode_d    = '0;
                frame_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q     <= StIdle;
            op1_q       <= '0;
            op2_q       <= '0;
            opcode_q    <= '0;
            result_q    <= '0;
            seen_busy_q <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            opcode_q    <= opcode_d;
            result_q    <= result_d;
            seen_busy_q <= seen_busy_d;
`ifdef SEQ_TIMEOUT_EN
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
`endif
        end
    end

    assign o_operand1 = op1_q;
    assign o_operand2 = op2_q;
    assign o_opcode   = opcode_q;
    assign o_busy     = (state_q != StIdle);
    assign o_tx_start = tx_start & i_reset;
    assign o_rx_drop  = rx_drop & i_reset;
    assign o_tx_data  = (state_q == StTxLo || state_q == StWaitLo) ? result_q[NB_DATA-1:0]
                                                                   : result_q[NB_OUT-1:NB_DATA];
`ifdef SEQ_TIMEOUT_EN
    assign o_frame_err = frame_err_q;
`else
    assign o_frame_err = 1'b0;
`endif

endmodule
